// File: rtl/logic_fifo_synchronous.sv
// Single-clock AXI4-Stream FIFO with a registered show-ahead output stage.
// Storage is a CAPACITY-1 entry memory plus the output register. The level,
// the ready/valid outputs and the fill flags are all registered.
`timescale 1ns/1ps

module logic_fifo_synchronous #(
    parameter int WIDTH        = 1,
    parameter int CAPACITY     = 16,
    parameter int ALMOST_FULL  = CAPACITY - 1,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                              aclk,
    input  logic                              areset_n,
    input  logic                              rx_tvalid,
    input  logic [WIDTH-1:0]                  rx_tdata,
    output logic                              rx_tready,
    output logic                              tx_tvalid,
    output logic [WIDTH-1:0]                  tx_tdata,
    input  logic                              tx_tready,
    output logic [$clog2(CAPACITY+1)-1:0]     level,
    output logic                              almost_full,
    output logic                              almost_empty
);

    localparam int LW    = $clog2(CAPACITY + 1);
    localparam int DEPTH = CAPACITY - 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [LW-1:0] CAP_L      = LW'(CAPACITY);
    localparam logic [LW-1:0] AF_L       = LW'(ALMOST_FULL);
    localparam logic [LW-1:0] AE_L       = LW'(ALMOST_EMPTY);
    localparam logic [LW-1:0] ONE_L      = LW'(1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

    // Elaboration-time parameter checks
    if (CAPACITY < 2) begin : g_drc_capacity
        $error("logic_fifo_synchronous: CAPACITY must be >= 2");
    end
    if (ALMOST_FULL < 1 || ALMOST_FULL > CAPACITY) begin : g_drc_af
        $error("logic_fifo_synchronous: ALMOST_FULL out of range");
    end
    if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > CAPACITY - 1) begin : g_drc_ae
        $error("logic_fifo_synchronous: ALMOST_EMPTY out of range");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic             wr;
    logic             rd;
    logic             mem_empty;
    logic             out_free;
    logic             load_mem;
    logic             bypass;
    logic             mem_wr;
    logic             tvalid_next;
    logic [LW-1:0]    level_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake decode and output-stage steering. The output register is
    // always filled first, so memory holds level-1 entries whenever level>0.
    always_comb begin
        wr          = rx_tvalid & rx_tready;
        rd          = tx_tvalid & tx_tready;
        mem_empty   = (level <= ONE_L);
        out_free    = !tx_tvalid || rd;
        load_mem    = out_free && !mem_empty;
        bypass      = out_free && mem_empty && wr;
        mem_wr      = wr && !bypass;
        tvalid_next = load_mem || bypass || (tx_tvalid && !rd);
        level_next  = level + LW'(wr) - LW'(rd);
    end

    // Control state: pointers, valid, level and flags derived from next level
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            tx_tvalid    <= 1'b0;
            level        <= '0;
            rx_tready    <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (mem_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (load_mem) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            tx_tvalid    <= tvalid_next;
            level        <= level_next;
            rx_tready    <= (level_next < CAP_L);
            almost_full  <= (level_next >= AF_L);
            almost_empty <= (level_next <= AE_L);
        end
    end

    // Data path: memory writes and output register load (no reset needed)
    always_ff @(posedge aclk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= rx_tdata;
        end
        if (load_mem) begin
            tx_tdata <= mem[rd_ptr];
        end else if (bypass) begin
            tx_tdata <= rx_tdata;
        end
    end

    // Occupancy sanity: level bounded and output valid tracks non-empty
    always_ff @(posedge aclk) begin
        if (areset_n) begin
            assert (level <= CAP_L);
            assert (tx_tvalid == (level != '0));
        end
    end

endmodule

// File: tb/tb_logic_fifo_synchronous.sv
// Self-checking bench for logic_fifo_synchronous (WIDTH=8, CAPACITY=16).
// A reference occupancy model plus a data scoreboard predicts every output.
`timescale 1ns/1ps

module tb_logic_fifo_synchronous;

    localparam int W   = 8;
    localparam int CAP = 16;
    localparam int LW  = $clog2(CAP + 1);

    logic          aclk = 1'b0;
    logic          areset_n;
    logic          rx_tvalid;
    logic [W-1:0]  rx_tdata;
    logic          rx_tready;
    logic          tx_tvalid;
    logic [W-1:0]  tx_tdata;
    logic          tx_tready;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          almost_empty;

    always #5 aclk = ~aclk;

    logic_fifo_synchronous #(
        .WIDTH        (W),
        .CAPACITY     (CAP),
        .ALMOST_FULL  (CAP - 1),
        .ALMOST_EMPTY (1)
    ) dut (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .rx_tvalid    (rx_tvalid),
        .rx_tdata     (rx_tdata),
        .rx_tready    (rx_tready),
        .tx_tvalid    (tx_tvalid),
        .tx_tdata     (tx_tdata),
        .tx_tready    (tx_tready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] sb[$];
    int           exp_level;
    bit           exp_rdy;
    int           n_rd;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: predict handshakes from the model, advance, then compare
    task automatic step();
        bit           rst;
        bit           wr;
        bit           rd;
        bit           hold;
        logic [W-1:0] held;
        rst  = !areset_n;
        wr   = !rst && rx_tvalid && exp_rdy;
        rd   = !rst && (exp_level > 0) && tx_tready;
        hold = !rst && (exp_level > 0) && !tx_tready;
        held = tx_tdata;
        if (rd && sb.size() > 0) begin
            check_eq("rd_data", tx_tdata, sb.pop_front());
        end
        if (wr) begin
            sb.push_back(rx_tdata);
        end
        @(posedge aclk);
        #1;
        if (rst) begin
            sb.delete();
            exp_level = 0;
            exp_rdy   = 1'b0;
        end else begin
            exp_level = exp_level + int'(wr) - int'(rd);
            exp_rdy   = (exp_level < CAP);
            n_rd      = n_rd + int'(rd);
        end
        check_eq("level", level, exp_level);
        check_eq("tx_tvalid", tx_tvalid, exp_level > 0);
        check_eq("rx_tready", rx_tready, exp_rdy);
        check_eq("almost_full", almost_full, exp_level >= CAP - 1);
        check_eq("almost_empty", almost_empty, exp_level <= 1);
        if (exp_level > 0 && sb.size() > 0) begin
            check_eq("tx_head", tx_tdata, sb[0]);
        end
        if (hold && !rst) begin
            check_eq("tx_stable", tx_tdata, held);
        end
    endtask

    task automatic drain();
        rx_tvalid = 1'b0;
        tx_tready = 1'b1;
        for (int i = 0; i < 2 * CAP && exp_level > 0; i++) begin
            step();
        end
        check_eq("drained", level, 0);
        tx_tready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d;
        bit           acc;

        areset_n  = 1'b0;
        rx_tvalid = 1'b0;
        rx_tdata  = '0;
        tx_tready = 1'b0;
        exp_level = 0;
        exp_rdy   = 1'b0;
        n_rd      = 0;

        // Reset, then release: rx_tready rises one edge later
        step();
        step();
        check_eq("rst_almost_empty", almost_empty, 1);
        areset_n = 1'b1;
        step();

        // Single write with 1-cycle latency, then read back
        rx_tvalid = 1'b1;
        rx_tdata  = 8'hA5;
        step();
        rx_tvalid = 1'b0;
        check_eq("single_tdata", tx_tdata, 8'hA5);
        check_eq("single_level", level, 1);
        tx_tready = 1'b1;
        step();
        check_eq("single_drain_level", level, 0);
        tx_tready = 1'b0;

        // Fill to capacity with extra writes offered while full
        d = 8'd0;
        rx_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc = exp_rdy;
            rx_tdata = d;
            step();
            if (acc) d++;
        end
        check_eq("full_level", level, 16);
        check_eq("full_rdy", rx_tready, 0);
        check_eq("full_af", almost_full, 1);
        rx_tvalid = 1'b0;
        tx_tready = 1'b1;
        step();
        check_eq("drain_rdy_back", rx_tready, 1);
        drain();

        // Continuous streaming: level pinned at 1
        rx_tvalid = 1'b1;
        tx_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rx_tdata = 8'(100 + i);
            step();
            check_eq("stream_level", level, 1);
        end
        drain();

        // Full with simultaneous read and offered write
        rx_tvalid = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            rx_tdata = 8'(200 + i);
            step();
        end
        check_eq("full2_level", level, 16);
        tx_tready = 1'b1;
        rx_tdata  = 8'hEE;
        step();
        check_eq("full_rd_level", level, 15);
        step();
        check_eq("full_rdwr_level", level, 15);
        drain();

        // Reset mid-stream at level 9
        rx_tvalid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_tdata = 8'(8'h50 + i);
            step();
        end
        check_eq("pre_rst_level", level, 9);
        areset_n = 1'b0;
        step();
        check_eq("mid_rst_level", level, 0);
        check_eq("mid_rst_tvalid", tx_tvalid, 0);
        check_eq("mid_rst_rdy", rx_tready, 0);
        areset_n = 1'b1;
        rx_tdata = 8'h3C;
        step();
        step();
        check_eq("post_rst_tdata", tx_tdata, 8'h3C);
        check_eq("post_rst_level", level, 1);
        drain();

        // Random valid/ready traffic
        n_rd = 0;
        for (int c = 0; c < 60000 && n_rd < 10000; c++) begin
            rx_tvalid = 1'($urandom_range(0, 1));
            tx_tready = 1'($urandom_range(0, 1));
            rx_tdata  = 8'($urandom);
            step();
        end
        check_eq("random_reads_done", n_rd >= 10000, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
